game_countdown_timer: RTL
=========================

Name: game_countdown_timer

Overview:
- Countdown timer that sits directly upstream of the game FSM and drives its timer_expired input.
- Loads GAME_SECONDS when the FSM starts a round, then decrements once per second using an internal prescaler on clkIn.
- Asserts timer_expired when the count reaches zero.
- Also outputs the remaining time as binary and as two BCD digits for the seven-segment display path.

Parameters:
- GAME_SECONDS, 30, round length in seconds; legal range 1..59.
- TICK_DIV, 100_000_000, clkIn cycles per second; benches override it with a small value such as 4.

Ports:
- clkIn  input  1  100 MHz system clock; the only clock in the block.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  begin a round; sampled only in IDLE.
- pause  input  1  level; while high, freezes both the prescaler and the count.
- clear  input  1  return from EXPIRED to IDLE; sampled only in EXPIRED.
- running  output  1  high while in COUNTING.
- timer_expired  output  1  level; high while in EXPIRED.
- expire_pulse  output  1  one-cycle strobe on entry to EXPIRED.
- time_left  output  6  seconds remaining, binary.
- time_tens  output  4  BCD tens digit of time_left.
- time_ones  output  4  BCD ones digit of time_left.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prescaler=0.
  - time_left=GAME_SECONDS; time_tens and time_ones set to the BCD digits of GAME_SECONDS.
  - running=0, timer_expired=0, expire_pulse=0.
- All outputs are registered. Reset released mid-round always restarts the block in IDLE.
- States:
  - IDLE: time_left held at GAME_SECONDS. If start=1, load prescaler=0 and go to COUNTING on the next edge.
  - COUNTING:
    - pause=0: prescaler increments each cycle. When prescaler==TICK_DIV-1, it wraps to 0 and a one-cycle sec_tick fires.
    - pause=1: prescaler and count hold their values, and no sec_tick fires.
    - On sec_tick: time_left decrements by 1.
      - ones==0 → ones=9 and tens decrements.
      - Otherwise ones decrements.
    - If time_left==1 at sec_tick: in the same edge time_left goes to 0, state goes to EXPIRED, and expire_pulse=1 for exactly that one cycle.
  - EXPIRED:
    - timer_expired=1 and time_left=0, held there.
    - If clear=1: go to IDLE and reload GAME_SECONDS on the same edge.
- Latency:
  - running rises 1 cycle after start is sampled.
  - The first decrement occurs TICK_DIV cycles after entering COUNTING, so the first second is always a full second.
  - timer_expired rises GAME_SECONDS*TICK_DIV cycles after COUNTING is entered, plus any paused cycles.
- Boundary rules:
  - start while COUNTING or EXPIRED: ignored.
  - clear outside EXPIRED: ignored.
  - pause and a would-be tick in the same cycle: pause wins, and the tick is deferred until pause drops (the prescaler holds at TICK_DIV-1).
  - start and pause both high in IDLE: enter COUNTING, then hold frozen.
  - The count never underflows. time_left==0 occurs only in EXPIRED.
- Invariant: time_tens*10 + time_ones == time_left in every cycle, and both digits stay ≤9.
- Prescaler width: clog2(TICK_DIV).

Decomposition:
- Shared package game_pkg holds:
  - timer state encodings IDLE/COUNTING/EXPIRED (2 bits);
  - default GAME_SECONDS=30;
  - SECONDS_W=6 and BCD_W=4.
- One sub-module, tick_prescaler:
  - ports: clkIn, reset, enable, restart; output tick;
  - a counter that emits one cycle every TICK_DIV enabled cycles.
- The countdown FSM and BCD counter stay in the top module.

Test Plan (TICK_DIV=4, GAME_SECONDS=3 unless noted):
- Reset, then start pulse → running=1 next cycle; time_left 3→2→1→0 at cycles 4, 8, 12 after entry. expire_pulse is high for exactly 1 cycle at cycle 12; timer_expired stays 1 until clear.
- GAME_SECONDS=30 → digits go 3/0 → 2/9 → 2/8. After 30 ticks: tens=0, ones=0. The BCD invariant is checked every cycle.
- Assert pause for 10 cycles midway through second 2 → expiry is delayed by exactly 10 cycles. No tick fires while paused.
- Pulse start during COUNTING and pulse clear during COUNTING → no effect on count or state.
- Drop reset for 1 cycle at time_left=1 → IDLE, time_left=3, all flags 0. A fresh start gives the full 12-cycle round.
- In EXPIRED, assert clear → IDLE with time_left=3. start in the same cycle as clear is ignored. A later start begins a new round.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game countdown timer.
//   - timer_state_e : countdown FSM state encoding (2 bits)
//   - DEFAULT_GAME_SECONDS : default round length in seconds
//   - SECONDS_W / BCD_W : widths of the binary seconds count and one BCD digit
package game_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } timer_state_e;

  localparam int DEFAULT_GAME_SECONDS = 30;
  localparam int SECONDS_W            = 6;
  localparam int BCD_W                = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clkIn down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clkIn   - system clock
//   reset   - asynchronous active-low reset
//   enable  - count this cycle (low freezes the counter, no tick)
//   restart - force the counter back to zero (takes priority)
//   tick    - high in the cycle the counter sits at TICK_DIV-1 while enabled;
//             the counter wraps to zero on that same edge
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clkIn,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  // Keep at least one bit so TICK_DIV == 1 still elaborates.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational so the consumer updates on the same edge the counter wraps.
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer feeding the game FSM's timer_expired input.
// Loads GAME_SECONDS on start, counts down once per TICK_DIV clkIn cycles,
// and parks in EXPIRED at zero until clear returns it to IDLE.
// Ports:
//   clkIn         - system clock (only clock)
//   reset         - asynchronous active-low reset
//   start         - begin a round (IDLE only)
//   pause         - level; freezes prescaler and count while high
//   clear         - leave EXPIRED for IDLE (EXPIRED only)
//   running       - high while COUNTING
//   timer_expired - high while EXPIRED
//   expire_pulse  - one-cycle strobe on entry to EXPIRED
//   time_left     - seconds remaining, binary
//   time_tens     - BCD tens digit of time_left
//   time_ones     - BCD ones digit of time_left
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int GAME_SECONDS = DEFAULT_GAME_SECONDS,
  parameter int TICK_DIV     = 100_000_000
) (
  input  logic                 clkIn,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 clear,
  output logic                 running,
  output logic                 timer_expired,
  output logic                 expire_pulse,
  output logic [SECONDS_W-1:0] time_left,
  output logic [BCD_W-1:0]     time_tens,
  output logic [BCD_W-1:0]     time_ones
);

  localparam logic [SECONDS_W-1:0] INIT_LEFT = SECONDS_W'(GAME_SECONDS);
  localparam logic [BCD_W-1:0]     INIT_TENS = BCD_W'(GAME_SECONDS / 10);
  localparam logic [BCD_W-1:0]     INIT_ONES = BCD_W'(GAME_SECONDS % 10);

  timer_state_e         state_q, state_d;
  logic [SECONDS_W-1:0] left_q, left_d;
  logic [BCD_W-1:0]     tens_q, tens_d;
  logic [BCD_W-1:0]     ones_q, ones_d;
  logic                 running_q, expired_q, pulse_q;
  logic                 sec_tick;

  // Prescaler is held at zero outside COUNTING so every round's first
  // second is a full TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clkIn   (clkIn),
    .reset   (reset),
    .enable  ((state_q == COUNTING) && !pause),
    .restart (state_q != COUNTING),
    .tick    (sec_tick)
  );

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        left_d = INIT_LEFT;
        tens_d = INIT_TENS;
        ones_d = INIT_ONES;
        if (start) begin
          state_d = COUNTING;
        end
      end
      COUNTING: begin
        if (sec_tick) begin
          left_d = left_q - 1'b1;
          if (ones_q == '0) begin
            ones_d = BCD_W'(9);
            tens_d = tens_q - 1'b1;
          end else begin
            ones_d = ones_q - 1'b1;
          end
          // Last second elapsed: count lands on zero as we enter EXPIRED.
          if (left_q == SECONDS_W'(1)) begin
            state_d = EXPIRED;
          end
        end
      end
      EXPIRED: begin
        if (clear) begin
          state_d = IDLE;
          left_d  = INIT_LEFT;
          tens_d  = INIT_TENS;
          ones_d  = INIT_ONES;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      left_q    <= INIT_LEFT;
      tens_q    <= INIT_TENS;
      ones_q    <= INIT_ONES;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      // Flags are registered from the next state so they line up with it.
      running_q <= (state_d == COUNTING);
      expired_q <= (state_d == EXPIRED);
      pulse_q   <= (state_q == COUNTING) && (state_d == EXPIRED);
    end
  end

  assign running       = running_q;
  assign timer_expired = expired_q;
  assign expire_pulse  = pulse_q;
  assign time_left     = left_q;
  assign time_tens     = tens_q;
  assign time_ones     = ones_q;

endmodule
